decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_pkg.sv | 97 +++++++++
 rtl/decode_stage_regfile.sv | 30 +++
 rtl/decode_stage.sv | 134 +++++++++++++
 tb/tb_decode_stage.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared decode constants, the control bundle type and the instruction decoder.
package decode_pkg;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    // Primary opcodes, instruction bits [31:26]
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes, instruction bits [5:0]
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    typedef struct packed {
        logic [4:0]  dest;
        logic [31:0] imm;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        alu_src;
        logic        branch;
        logic        jump;
        logic        illegal;
    } ctrl_t;

    // Pure combinational decode of one instruction word.
    function automatic ctrl_t decode(input logic [31:0] instr);
        ctrl_t       c;
        logic [5:0]  op;
        logic [5:0]  fn;
        op = instr[31:26];
        fn = instr[5:0];
        c  = '0;
        c.imm = {{16{instr[15]}}, instr[15:0]};
        unique case (op)
            OP_RTYPE: begin
                unique case (fn)
                    FN_SLL, FN_SRL, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
                    FN_AND, FN_OR, FN_SLT: begin
                        c.dest      = instr[15:11];
                        c.reg_write = 1'b1;
                    end
                    FN_JR:   c.jump    = 1'b1;
                    default: c.illegal = 1'b1;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: begin
                c.dest      = instr[20:16];
                c.alu_src   = 1'b1;
                c.reg_write = 1'b1;
                if (op == OP_ANDI || op == OP_ORI) c.imm = {16'h0000, instr[15:0]};
                if (op == OP_LUI)                  c.imm = {instr[15:0], 16'h0000};
            end
            OP_LW: begin
                c.dest      = instr[20:16];
                c.mem_read  = 1'b1;
                c.reg_write = 1'b1;
                c.alu_src   = 1'b1;
            end
            OP_SW: begin
                c.mem_write = 1'b1;
                c.alu_src   = 1'b1;
            end
            OP_BEQ, OP_BNE: c.branch = 1'b1;
            OP_J:           c.jump   = 1'b1;
            OP_JAL: begin
                c.jump      = 1'b1;
                c.reg_write = 1'b1;
                c.dest      = 5'd31;
            end
            default: c.illegal = 1'b1;
        endcase
        // Writes to $0 are architecturally discarded, so never request one.
        if (c.dest == 5'd0) c.reg_write = 1'b0;
        return c;
    endfunction

endpackage

// File: rtl/decode_stage_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port.
module regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic [4:0]  rd_addr_a,
    output logic [31:0] rd_data_a,
    input  logic [4:0]  rd_addr_b,
    output logic [31:0] rd_data_b
);

    logic [31:0] mem [32];

    // Register write; reset clears every entry so the pipeline starts from a known state.
    // NOTE: this array is reset on purpose (registers must read 0 after reset), which keeps it
    // out of block RAM; arrays without that need should be left unreset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) mem[i] <= '0;
        end else if (wr_en && wr_addr != 5'd0) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data_a = (rd_addr_a == 5'd0) ? 32'h0 : mem[rd_addr_a];
    assign rd_data_b = (rd_addr_b == 5'd0) ? 32'h0 : mem[rd_addr_b];

endmodule

// File: rtl/decode_stage.sv
// Pipeline decode stage: one-entry skid-free register between fetch and execute,
// with field decode, operand read and write-back bypass.
module decode_stage
    import decode_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_valid,
    output logic        if_ready,
    input  logic [31:0] instruction,
    input  logic [31:0] pc_current,
    input  logic [31:0] pc_next,
    input  logic        flush,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_next,
    output logic [4:0]  id_rs,
    output logic [4:0]  id_rt,
    output logic [4:0]  id_dest,
    output logic [4:0]  id_shamt,
    output logic [5:0]  id_funct,
    output logic [31:0] id_imm,
    output logic [31:0] id_rs_data,
    output logic [31:0] id_rt_data,
    output logic        id_reg_write,
    output logic        id_mem_read,
    output logic        id_mem_write,
    output logic        id_alu_src,
    output logic        id_branch,
    output logic        id_jump,
    output logic        id_illegal
);

    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [31:0] rf_rs_data;
    logic [31:0] rf_rt_data;
    logic [31:0] cap_rs_data;
    logic [31:0] cap_rt_data;
    logic        capture;
    logic        stall;
    ctrl_t       dec;

    assign in_rs    = instruction[25:21];
    assign in_rt    = instruction[20:16];
    assign if_ready = !id_valid || id_ready;
    assign capture  = if_valid && if_ready && !flush;
    assign stall    = id_valid && !id_ready;

    regfile u_regfile (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wb_en),
        .wr_addr   (wb_addr),
        .wr_data   (wb_data),
        .rd_addr_a (in_rs),
        .rd_data_a (rf_rs_data),
        .rd_addr_b (in_rt),
        .rd_data_b (rf_rt_data)
    );

    // Decode the incoming word and bypass a same-cycle register write into its operands.
    // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
    always_comb begin
        dec         = decode(instruction);
        cap_rs_data = rf_rs_data;
        cap_rt_data = rf_rt_data;
        if (wb_en && in_rs != 5'd0 && wb_addr == in_rs) cap_rs_data = wb_data;
        if (wb_en && in_rt != 5'd0 && wb_addr == in_rt) cap_rt_data = wb_data;
    end

    // Stage register: reset > flush > capture > drain / stall operand refresh.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            id_valid     <= 1'b0;
            id_instr     <= NOP_INSTR;
            id_pc        <= '0;
            id_pc_next   <= '0;
            id_rs        <= '0;
            id_rt        <= '0;
            id_dest      <= '0;
            id_shamt     <= '0;
            id_funct     <= '0;
            id_imm       <= '0;
            id_rs_data   <= '0;
            id_rt_data   <= '0;
            id_reg_write <= 1'b0;
            id_mem_read  <= 1'b0;
            id_mem_write <= 1'b0;
            id_alu_src   <= 1'b0;
            id_branch    <= 1'b0;
            id_jump      <= 1'b0;
            id_illegal   <= 1'b0;
        end else if (flush) begin
            id_valid <= 1'b0;
            id_instr <= NOP_INSTR;
        end else if (capture) begin
            id_valid     <= 1'b1;
            id_instr     <= instruction;
            id_pc        <= pc_current;
            id_pc_next   <= pc_next;
            id_rs        <= in_rs;
            id_rt        <= in_rt;
            id_dest      <= dec.dest;
            id_shamt     <= instruction[10:6];
            id_funct     <= instruction[5:0];
            id_imm       <= dec.imm;
            id_rs_data   <= cap_rs_data;
            id_rt_data   <= cap_rt_data;
            id_reg_write <= dec.reg_write;
            id_mem_read  <= dec.mem_read;
            id_mem_write <= dec.mem_write;
            id_alu_src   <= dec.alu_src;
            id_branch    <= dec.branch;
            id_jump      <= dec.jump;
            id_illegal   <= dec.illegal;
        end else if (stall) begin
            // Held operands track writes that land while execute is not accepting.
            if (wb_en && id_rs != 5'd0 && wb_addr == id_rs) id_rs_data <= wb_data;
            if (wb_en && id_rt != 5'd0 && wb_addr == id_rt) id_rt_data <= wb_data;
        end else begin
            id_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed, table-driven bench for decode_stage.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] instruction;
    logic [31:0] pc_current;
    logic [31:0] pc_next;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_next;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_dest;
    logic [4:0]  id_shamt;
    logic [5:0]  id_funct;
    logic [31:0] id_imm;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic        id_reg_write;
    logic        id_mem_read;
    logic        id_mem_write;
    logic        id_alu_src;
    logic        id_branch;
    logic        id_jump;
    logic        id_illegal;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] R1 = 32'hA1A1_0001;
    localparam logic [31:0] R2 = 32'hB2B2_0002;
    localparam logic [31:0] R4 = 32'hC4C4_0004;
    localparam logic [31:0] I_ADD = 32'h0022_1820;
    localparam logic [31:0] I_LUI = 32'h3C06_1234;
    localparam logic [31:0] I_LW  = 32'h8C22_0004;

    // {reg_write, mem_read, mem_write, alu_src, branch, jump, illegal}
    typedef struct {
        logic [31:0] instr;
        logic [4:0]  dest;
        logic [31:0] imm;
        logic [6:0]  ctrl;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    decode_stage dut (
        .clk          (clk),
        .reset        (reset),
        .if_valid     (if_valid),
        .if_ready     (if_ready),
        .instruction  (instruction),
        .pc_current   (pc_current),
        .pc_next      (pc_next),
        .flush        (flush),
        .wb_en        (wb_en),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .id_valid     (id_valid),
        .id_ready     (id_ready),
        .id_instr     (id_instr),
        .id_pc        (id_pc),
        .id_pc_next   (id_pc_next),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_dest      (id_dest),
        .id_shamt     (id_shamt),
        .id_funct     (id_funct),
        .id_imm       (id_imm),
        .id_rs_data   (id_rs_data),
        .id_rt_data   (id_rt_data),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .id_mem_write (id_mem_write),
        .id_alu_src   (id_alu_src),
        .id_branch    (id_branch),
        .id_jump      (id_jump),
        .id_illegal   (id_illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] ctrl_now();
        return {id_reg_write, id_mem_read, id_mem_write, id_alu_src, id_branch, id_jump, id_illegal};
    endfunction

    task automatic wb_write(input logic [4:0] addr, input logic [31:0] data);
        wb_en   = 1'b1;
        wb_addr = addr;
        wb_data = data;
        step();
        wb_en   = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{32'h0022_1820, 5'd3,  32'h0000_1820, 7'b1000000, R1,    R2};
        vecs[1]  = '{32'h3024_8000, 5'd4,  32'h0000_8000, 7'b1001000, R1,    R4};
        vecs[2]  = '{32'h2045_FFFF, 5'd5,  32'hFFFF_FFFF, 7'b1001000, R2,    32'h0};
        vecs[3]  = '{32'h3C06_1234, 5'd6,  32'h1234_0000, 7'b1001000, 32'h0, 32'h0};
        vecs[4]  = '{32'hAC22_0008, 5'd0,  32'h0000_0008, 7'b0011000, R1,    R2};
        vecs[5]  = '{32'h1022_FFFC, 5'd0,  32'hFFFF_FFFC, 7'b0000100, R1,    R2};
        vecs[6]  = '{32'h0800_0100, 5'd0,  32'h0000_0100, 7'b0000010, 32'h0, 32'h0};
        vecs[7]  = '{32'h0C00_0010, 5'd31, 32'h0000_0010, 7'b1000010, 32'h0, 32'h0};
        vecs[8]  = '{32'h0020_0008, 5'd0,  32'h0000_0008, 7'b0000010, R1,    32'h0};
        vecs[9]  = '{32'hFC00_0000, 5'd0,  32'h0000_0000, 7'b0000001, 32'h0, 32'h0};
        vecs[10] = '{32'h2400_FFFF, 5'd0,  32'hFFFF_FFFF, 7'b0001000, 32'h0, 32'h0};
        vecs[11] = '{32'h0022_1826, 5'd0,  32'h0000_1826, 7'b0000001, R1,    R2};
        vecs[12] = '{32'h0002_1900, 5'd3,  32'h0000_1900, 7'b1000000, 32'h0, R2};
        vecs[13] = '{32'h0022_0020, 5'd0,  32'h0000_0020, 7'b0000000, R1,    R2};
        vecs[14] = '{32'h8C22_0004, 5'd2,  32'h0000_0004, 7'b1101000, R1,    R2};
        vecs[15] = '{32'h1480_0003, 5'd0,  32'h0000_0003, 7'b0000100, R4,    32'h0};
        vecs[16] = '{32'h0004_3842, 5'd7,  32'h0000_3842, 7'b1000000, 32'h0, R4};

        // Reset wins over a pending capture and a register write.
        reset       = 1'b1;
        if_valid    = 1'b1;
        instruction = I_LW;
        pc_current  = 32'h0000_0100;
        pc_next     = 32'h0000_0104;
        flush       = 1'b0;
        wb_en       = 1'b1;
        wb_addr     = 5'd1;
        wb_data     = 32'hDEAD_BEEF;
        id_ready    = 1'b1;
        step();
        step();
        check("rst id_valid",   {31'b0, id_valid}, 32'h0);
        check("rst id_instr",   id_instr,          32'h0);
        check("rst id_imm",     id_imm,            32'h0);
        check("rst id_dest",    {27'b0, id_dest},  32'h0);
        check("rst ctrl",       {25'b0, ctrl_now()}, 32'h0);
        check("rst id_rs_data", id_rs_data,        32'h0);
        check("rst id_pc",      id_pc,             32'h0);
        check("rst if_ready",   {31'b0, if_ready}, 32'h1);

        // lw $2,4($1): one-cycle capture latency; $1 must still read 0.
        reset = 1'b0;
        wb_en = 1'b0;
        step();
        check("lw id_valid",    {31'b0, id_valid},     32'h1);
        check("lw mem_read",    {31'b0, id_mem_read},  32'h1);
        check("lw reg_write",   {31'b0, id_reg_write}, 32'h1);
        check("lw dest",        {27'b0, id_dest},      32'h2);
        check("lw imm",         id_imm,                32'h4);
        check("lw pc",          id_pc,                 32'h0000_0100);
        check("lw rs_data",     id_rs_data,            32'h0);

        // Drain: accepted with nothing new behind it.
        if_valid = 1'b0;
        step();
        check("drain id_valid", {31'b0, id_valid}, 32'h0);

        // Preload registers; the $0 write must be dropped.
        wb_write(5'd1, R1);
        wb_write(5'd2, R2);
        wb_write(5'd4, R4);
        wb_write(5'd0, 32'hDEAD_BEEF);

        // Back-to-back captures from the decode table.
        for (int i = 0; i < NVEC; i++) begin
            instruction = vecs[i].instr;
            pc_current  = 32'h0000_0400 + 32'(4 * i);
            pc_next     = 32'h0000_0404 + 32'(4 * i);
            if_valid    = 1'b1;
            step();
            check($sformatf("v%0d valid", i),   {31'b0, id_valid}, 32'h1);
            check($sformatf("v%0d instr", i),   id_instr, vecs[i].instr);
            check($sformatf("v%0d pc", i),      id_pc, 32'h0000_0400 + 32'(4 * i));
            check($sformatf("v%0d pc_next", i), id_pc_next, 32'h0000_0404 + 32'(4 * i));
            check($sformatf("v%0d rs", i),      {27'b0, id_rs}, {27'b0, vecs[i].instr[25:21]});
            check($sformatf("v%0d rt", i),      {27'b0, id_rt}, {27'b0, vecs[i].instr[20:16]});
            check($sformatf("v%0d shamt", i),   {27'b0, id_shamt}, {27'b0, vecs[i].instr[10:6]});
            check($sformatf("v%0d funct", i),   {26'b0, id_funct}, {26'b0, vecs[i].instr[5:0]});
            check($sformatf("v%0d dest", i),    {27'b0, id_dest}, {27'b0, vecs[i].dest});
            check($sformatf("v%0d imm", i),     id_imm, vecs[i].imm);
            check($sformatf("v%0d ctrl", i),    {25'b0, ctrl_now()}, {25'b0, vecs[i].ctrl});
            check($sformatf("v%0d rs_data", i), id_rs_data, vecs[i].rs_data);
            check($sformatf("v%0d rt_data", i), id_rt_data, vecs[i].rt_data);
        end
        if_valid = 1'b0;
        step();

        // Stall: three cycles of backpressure with a new word waiting.
        instruction = I_ADD;
        if_valid    = 1'b1;
        id_ready    = 1'b1;
        step();
        id_ready    = 1'b0;
        instruction = I_LUI;
        #1;
        check("stall if_ready", {31'b0, if_ready}, 32'h0);
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("stall%0d instr", c),    id_instr, I_ADD);
            check($sformatf("stall%0d valid", c),    {31'b0, id_valid}, 32'h1);
            check($sformatf("stall%0d dest", c),     {27'b0, id_dest}, 32'h3);
            check($sformatf("stall%0d if_ready", c), {31'b0, if_ready}, 32'h0);
        end
        id_ready = 1'b1;
        #1;
        check("release if_ready", {31'b0, if_ready}, 32'h1);
        step();
        check("release instr", id_instr, I_LUI);
        check("release dest",  {27'b0, id_dest}, 32'h6);

        // Refresh of a held operand during a stall.
        instruction = I_ADD;
        step();
        id_ready = 1'b0;
        if_valid = 1'b0;
        wb_write(5'd2, 32'h0000_00FF);
        check("refresh rt_data", id_rt_data, 32'h0000_00FF);
        check("refresh rs_data", id_rs_data, R1);
        check("refresh instr",   id_instr,   I_ADD);

        // Flush while stalled and fetch is offering a word.
        flush       = 1'b1;
        if_valid    = 1'b1;
        instruction = I_LUI;
        step();
        check("flush valid", {31'b0, id_valid}, 32'h0);
        check("flush instr", id_instr, 32'h0);
        flush    = 1'b0;
        if_valid = 1'b0;

        // Write-back bypass at capture.
        id_ready    = 1'b1;
        instruction = I_ADD;
        if_valid    = 1'b1;
        wb_en       = 1'b1;
        wb_addr     = 5'd1;
        wb_data     = 32'h0000_0010;
        step();
        wb_en = 1'b0;
        check("bypass rs_data", id_rs_data, 32'h0000_0010);
        check("bypass rt_data", id_rt_data, 32'h0000_00FF);

        // Reset in the middle of a stall, against flush, fetch and write-back.
        step();
        id_ready = 1'b0;
        flush    = 1'b1;
        wb_en    = 1'b1;
        wb_addr  = 5'd5;
        wb_data  = 32'h0000_0055;
        reset    = 1'b1;
        step();
        check("mid rst valid",   {31'b0, id_valid}, 32'h0);
        check("mid rst instr",   id_instr, 32'h0);
        check("mid rst rs_data", id_rs_data, 32'h0);
        check("mid rst dest",    {27'b0, id_dest}, 32'h0);
        check("mid rst pc",      id_pc, 32'h0);
        reset    = 1'b0;
        flush    = 1'b0;
        wb_en    = 1'b0;
        id_ready = 1'b1;
        instruction = 32'h2045_FFFF; // addi $5,$2,-1: reads $2 and $5
        step();
        check("post rst rs_data", id_rs_data, 32'h0);
        check("post rst rt_data", id_rt_data, 32'h0);
        instruction = I_ADD;
        step();
        check("post rst r1", id_rs_data, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule
